// File: rtl/proc_pkg.sv
// Shared processor definitions: opcode encodings, write-back FSM states and
// the helper that decides which opcodes count as retired instructions.
package proc_pkg;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_LV   = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_MUL  = 5'd4;
  localparam logic [4:0] OP_DIV  = 5'd5;
  localparam logic [4:0] OP_CP   = 5'd6;
  localparam logic [4:0] OP_B    = 5'd7;
  localparam logic [4:0] OP_BEG  = 5'd8;
  localparam logic [4:0] OP_SLR  = 5'd9;
  localparam logic [4:0] OP_GP   = 5'd10;
  localparam logic [4:0] OP_HALT = 5'd31;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALT   = 2'd2
  } wb_state_e;

  // Undefined opcodes (11..30) and NOP never count as retirements.
  function automatic logic is_retiring_op(input logic [4:0] op);
    return ((op >= OP_LV) && (op <= OP_GP)) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Bundle between the MEM stage and the write-back stage: MEM-stage inputs,
// register-file write port, forwarding bus, redirect and status outputs.
interface wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 7
);

  logic              stall;
  logic [DATA_W-1:0] result_in;
  logic [RD_W-1:0]   rd_in;
  logic              wren_in;
  logic [RD_W-1:0]   branch_in;
  logic [4:0]        opcode_in;

  logic [DATA_W-1:0] rf_wdata;
  logic [RD_W-1:0]   rf_waddr;
  logic              rf_we;
  logic [DATA_W-1:0] fwd_data;
  logic [RD_W-1:0]   fwd_addr;
  logic              fwd_valid;
  logic              redirect_valid;
  logic [RD_W-1:0]   redirect_target;
  logic              squash;
  logic              halted;
  logic [31:0]       retired_cnt;

  modport master (
    output stall, result_in, rd_in, wren_in, branch_in, opcode_in,
    input  rf_wdata, rf_waddr, rf_we, fwd_data, fwd_addr, fwd_valid,
    input  redirect_valid, redirect_target, squash, halted, retired_cnt
  );

  modport slave (
    input  stall, result_in, rd_in, wren_in, branch_in, opcode_in,
    output rf_wdata, rf_waddr, rf_we, fwd_data, fwd_addr, fwd_valid,
    output redirect_valid, redirect_target, squash, halted, retired_cnt
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures the MEM-stage slot every non-stalled
// cycle and clears to a NOP on reset.
module mem_wb_reg
  import proc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic              wren_i,
  input  logic [RD_W-1:0]   branch_i,
  input  logic [4:0]        opcode_i,
  output logic [DATA_W-1:0] result_o,
  output logic [RD_W-1:0]   rd_o,
  output logic              wren_o,
  output logic [RD_W-1:0]   branch_o,
  output logic [4:0]        opcode_o
);

  logic [DATA_W-1:0] result_q;
  logic [RD_W-1:0]   rd_q;
  logic              wren_q;
  logic [RD_W-1:0]   branch_q;
  logic [4:0]        opcode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      rd_q     <= '0;
      wren_q   <= 1'b0;
      branch_q <= '0;
      opcode_q <= OP_NOP;
    end else if (!stall_i) begin
      result_q <= result_i;
      rd_q     <= rd_i;
      wren_q   <= wren_i;
      branch_q <= branch_i;
      opcode_q <= opcode_i;
    end
  end

  assign result_o = result_q;
  assign rd_o     = rd_q;
  assign wren_o   = wren_q;
  assign branch_o = branch_q;
  assign opcode_o = opcode_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires the MEM/WB slot into the register file, issues
// branch redirects, discards squashed younger slots and stops on HALT.
module wb_stage
  import proc_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int RD_W          = 7,
  parameter int SQUASH_CYCLES = 2
) (
  input logic        clk,
  input logic        rst,
  wb_stage_if.slave  bus
);

  localparam int CNT_W = (SQUASH_CYCLES < 2) ? 1 : $clog2(SQUASH_CYCLES + 1);
  localparam logic [CNT_W-1:0] SQ_LOAD = CNT_W'(SQUASH_CYCLES);

  logic [DATA_W-1:0] result_q;
  logic [RD_W-1:0]   rd_q;
  logic              wren_q;
  logic [RD_W-1:0]   branch_q;
  logic [4:0]        opcode_q;

  wb_state_e         state_q;
  logic [CNT_W-1:0]  sq_cnt_q;
  logic [31:0]       retired_q;
  logic [31:0]       retired_d;

  logic              in_run;
  logic              retire;
  logic              branch_taken;

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .RD_W   (RD_W)
  ) u_mem_wb_reg (
    .clk      (clk),
    .rst      (rst),
    .stall_i  (bus.stall),
    .result_i (bus.result_in),
    .rd_i     (bus.rd_in),
    .wren_i   (bus.wren_in),
    .branch_i (bus.branch_in),
    .opcode_i (bus.opcode_in),
    .result_o (result_q),
    .rd_o     (rd_q),
    .wren_o   (wren_q),
    .branch_o (branch_q),
    .opcode_o (opcode_q)
  );

  assign in_run       = (state_q == ST_RUN);
  assign retire       = !bus.stall && in_run && is_retiring_op(opcode_q);
  // A HALT slot wins over any branch target it carries.
  assign branch_taken = in_run && (branch_q != '0) && (opcode_q != OP_HALT);
  assign retired_d    = retired_q + {31'b0, retire};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      sq_cnt_q  <= '0;
      retired_q <= '0;
    end else if (!bus.stall) begin
      retired_q <= retired_d;
      case (state_q)
        ST_RUN: begin
          if (opcode_q == OP_HALT) begin
            state_q <= ST_HALT;
          end else if (branch_taken && (SQUASH_CYCLES != 0)) begin
            state_q  <= ST_SQUASH;
            sq_cnt_q <= SQ_LOAD;
          end
        end
        // Branches carried by squashed slots are ignored here by design.
        ST_SQUASH: begin
          if (sq_cnt_q <= CNT_W'(1)) begin
            state_q  <= ST_RUN;
            sq_cnt_q <= '0;
          end else begin
            sq_cnt_q <= sq_cnt_q - CNT_W'(1);
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q  <= ST_RUN;
          sq_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.rf_we           = wren_q && in_run && (rd_q != '0) && !bus.stall;
  assign bus.rf_wdata        = result_q;
  assign bus.rf_waddr        = rd_q;
  assign bus.fwd_data        = result_q;
  assign bus.fwd_addr        = rd_q;
  assign bus.fwd_valid       = bus.rf_we;
  assign bus.redirect_valid  = branch_taken && !bus.stall;
  assign bus.redirect_target = bus.redirect_valid ? branch_q : '0;
  assign bus.squash          = (state_q == ST_SQUASH);
  assign bus.halted          = (state_q == ST_HALT);
  assign bus.retired_cnt     = retired_d;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table of per-cycle vectors whose expected
// outputs flow through a scoreboard queue, plus reset, wrap and zero-squash cases.
module tb_wb_stage;
  import proc_pkg::*;

  localparam int DW = 32;
  localparam int RW = 7;
  localparam int NVEC = 24;

  logic clk;
  logic rst;

  wb_stage_if #(.DATA_W(DW), .RD_W(RW)) bus ();
  wb_stage_if #(.DATA_W(DW), .RD_W(RW)) bus0 ();

  wb_stage #(.DATA_W(DW), .RD_W(RW), .SQUASH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wb_stage #(.DATA_W(DW), .RD_W(RW), .SQUASH_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  assign bus0.stall     = bus.stall;
  assign bus0.result_in = bus.result_in;
  assign bus0.rd_in     = bus.rd_in;
  assign bus0.wren_in   = bus.wren_in;
  assign bus0.branch_in = bus.branch_in;
  assign bus0.opcode_in = bus.opcode_in;

  typedef struct {
    logic        we;
    logic [6:0]  wa;
    logic [31:0] wd;
    logic        rv;
    logic [6:0]  rt;
    logic        sq;
    logic        hl;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic        st;
    logic [4:0]  op;
    logic [31:0] res;
    logic [6:0]  rd;
    logic        wr;
    logic [6:0]  br;
    exp_t        e;
  } vec_t;

  vec_t vecs [NVEC];
  exp_t sbQ [$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Vector = inputs driven this cycle + outputs expected this cycle (which
  // reflect the slot registered at the previous edge and the current stall).
  function automatic vec_t mk(input int st, input int op, input int res, input int rd,
                              input int wr, input int br, input int we, input int wa,
                              input int wd, input int rv, input int rt, input int sq,
                              input int hl, input int cnt);
    vec_t v;
    v.st = 1'(st);  v.op = 5'(op);  v.res = 32'(res);
    v.rd = 7'(rd);  v.wr = 1'(wr);  v.br = 7'(br);
    v.e.we = 1'(we);  v.e.wa = 7'(wa);  v.e.wd = 32'(wd);  v.e.rv = 1'(rv);
    v.e.rt = 7'(rt);  v.e.sq = 1'(sq);  v.e.hl = 1'(hl);  v.e.cnt = 32'(cnt);
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic driveIdle();
    bus.stall     = 1'b0;
    bus.result_in = '0;
    bus.rd_in     = '0;
    bus.wren_in   = 1'b0;
    bus.branch_in = '0;
    bus.opcode_in = OP_NOP;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.stall     = v.st;
    bus.result_in = v.res;
    bus.rd_in     = v.rd;
    bus.wren_in   = v.wr;
    bus.branch_in = v.br;
    bus.opcode_in = v.op;
    sbQ.push_back(v.e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    #2;
    if (sbQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s.queue: got empty scoreboard, want one entry", tag);
    end else begin
      e = sbQ.pop_front();
      checkVal({tag, ".rf_we"},     32'(bus.rf_we),           32'(e.we));
      checkVal({tag, ".fwd_valid"}, 32'(bus.fwd_valid),       32'(e.we));
      checkVal({tag, ".rf_waddr"},  32'(bus.rf_waddr),        32'(e.wa));
      checkVal({tag, ".fwd_addr"},  32'(bus.fwd_addr),        32'(e.wa));
      checkVal({tag, ".rf_wdata"},  bus.rf_wdata,             e.wd);
      checkVal({tag, ".fwd_data"},  bus.fwd_data,             e.wd);
      checkVal({tag, ".redir_v"},   32'(bus.redirect_valid),  32'(e.rv));
      checkVal({tag, ".redir_t"},   32'(bus.redirect_target), 32'(e.rt));
      checkVal({tag, ".squash"},    32'(bus.squash),          32'(e.sq));
      checkVal({tag, ".halted"},    32'(bus.halted),          32'(e.hl));
      checkVal({tag, ".retired"},   bus.retired_cnt,          e.cnt);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, ".rf_we"},     32'(bus.rf_we),           32'd0);
    checkVal({tag, ".rf_waddr"},  32'(bus.rf_waddr),        32'd0);
    checkVal({tag, ".rf_wdata"},  bus.rf_wdata,             32'd0);
    checkVal({tag, ".fwd_valid"}, 32'(bus.fwd_valid),       32'd0);
    checkVal({tag, ".fwd_addr"},  32'(bus.fwd_addr),        32'd0);
    checkVal({tag, ".fwd_data"},  bus.fwd_data,             32'd0);
    checkVal({tag, ".redir_v"},   32'(bus.redirect_valid),  32'd0);
    checkVal({tag, ".redir_t"},   32'(bus.redirect_target), 32'd0);
    checkVal({tag, ".squash"},    32'(bus.squash),          32'd0);
    checkVal({tag, ".halted"},    32'(bus.halted),          32'd0);
    checkVal({tag, ".retired"},   bus.retired_cnt,          32'd0);
  endtask

  initial begin
    //            st op        res    rd wr br      we wa wd     rv rt    sq hl cnt
    vecs[0]  = mk(0, OP_NOP,  0,     0, 0, 0,      0, 0, 0,     0, 0,    0, 0, 0);
    vecs[1]  = mk(0, OP_ADD,  'h12,  5, 1, 0,      0, 0, 0,     0, 0,    0, 0, 0);
    vecs[2]  = mk(0, OP_ADD,  'h34,  0, 1, 0,      1, 5, 'h12,  0, 0,    0, 0, 1);
    vecs[3]  = mk(0, OP_LV,   'h55,  3, 1, 0,      0, 0, 'h34,  0, 0,    0, 0, 2);
    vecs[4]  = mk(0, 12,      0,     4, 0, 0,      1, 3, 'h55,  0, 0,    0, 0, 3);
    vecs[5]  = mk(0, OP_B,    0,     0, 0, 'h14,   0, 4, 0,     0, 0,    0, 0, 3);
    vecs[6]  = mk(0, OP_ADD,  'hA1,  6, 1, 0,      0, 0, 0,     1, 'h14, 0, 0, 4);
    vecs[7]  = mk(0, OP_ADD,  'hA2,  7, 1, 'h22,   0, 6, 'hA1,  0, 0,    1, 0, 4);
    vecs[8]  = mk(0, OP_ADD,  'hA3,  8, 1, 0,      0, 7, 'hA2,  0, 0,    1, 0, 4);
    vecs[9]  = mk(0, OP_NOP,  0,     0, 0, 0,      1, 8, 'hA3,  0, 0,    0, 0, 5);
    vecs[10] = mk(0, OP_B,    0,     0, 0, 'h30,   0, 0, 0,     0, 0,    0, 0, 5);
    vecs[11] = mk(0, OP_ADD,  'hB1,  9, 1, 0,      0, 0, 0,     1, 'h30, 0, 0, 6);
    vecs[12] = mk(1, OP_ADD,  'hB2, 10, 1, 0,      0, 9, 'hB1,  0, 0,    1, 0, 6);
    vecs[13] = mk(1, OP_ADD,  'hB2, 10, 1, 0,      0, 9, 'hB1,  0, 0,    1, 0, 6);
    vecs[14] = mk(1, OP_ADD,  'hB2, 10, 1, 0,      0, 9, 'hB1,  0, 0,    1, 0, 6);
    vecs[15] = mk(0, OP_ADD,  'hB2, 10, 1, 0,      0, 9, 'hB1,  0, 0,    1, 0, 6);
    vecs[16] = mk(0, OP_ADD,  'hB3, 11, 1, 0,      0, 10, 'hB2, 0, 0,    1, 0, 6);
    vecs[17] = mk(1, OP_NOP,  0,     0, 0, 0,      0, 11, 'hB3, 0, 0,    0, 0, 6);
    vecs[18] = mk(0, OP_NOP,  0,     0, 0, 0,      1, 11, 'hB3, 0, 0,    0, 0, 7);
    vecs[19] = mk(0, OP_HALT, 0,     0, 0, 0,      0, 0, 0,     0, 0,    0, 0, 7);
    vecs[20] = mk(0, OP_LV,   'h77,  3, 1, 0,      0, 0, 0,     0, 0,    0, 0, 8);
    vecs[21] = mk(0, OP_NOP,  0,     0, 0, 0,      0, 3, 'h77,  0, 0,    0, 1, 8);
    vecs[22] = mk(0, OP_B,    0,     0, 0, 'h40,   0, 0, 0,     0, 0,    0, 1, 8);
    vecs[23] = mk(0, OP_LV,   'h77,  3, 1, 0,      0, 0, 0,     0, 0,    0, 1, 8);

    rst = 1'b1;
    driveIdle();
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d", i));
    end

    // Reset asserted between clock edges while halted with LV rd=3 registered.
    @(posedge clk);
    #2;
    checkVal("pre_rst.halted",   32'(bus.halted),   32'd1);
    checkVal("pre_rst.rf_we",    32'(bus.rf_we),    32'd0);
    checkVal("pre_rst.rf_waddr", 32'(bus.rf_waddr), 32'd3);
    rst = 1'b1;
    driveIdle();
    #1;
    checkAllZero("async_rst");
    checkVal("async_rst.halted0", 32'(bus0.halted), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(mk(0, OP_ADD, 'h12, 5, 1, 0,  0, 0, 0,    0, 0, 0, 0, 0));
    checkOutput("post_rst0");
    applyStimulus(mk(0, OP_NOP, 0,    0, 0, 0,  1, 5, 'h12, 0, 0, 0, 0, 1));
    checkOutput("post_rst1");

    // Counter preloaded to all-ones while stalled, then one ADD retires.
    applyStimulus(mk(1, OP_NOP, 0,    0, 0, 0,  0, 0, 0,    0, 0, 0, 0, 'hFFFF_FFFF));
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    checkOutput("wrap0");
    applyStimulus(mk(0, OP_ADD, 'h99, 9, 1, 0,  0, 0, 0,    0, 0, 0, 0, 'hFFFF_FFFF));
    checkOutput("wrap1");
    applyStimulus(mk(0, OP_NOP, 0,    0, 0, 0,  1, 9, 'h99, 0, 0, 0, 0, 0));
    checkOutput("wrap2");

    // Branch seen by both instances; the zero-squash one writes the next slot.
    applyStimulus(mk(0, OP_B,   0,    0, 0, 'h14, 0, 0, 0,  0, 0,    0, 0, 0));
    checkOutput("sq0_b");
    applyStimulus(mk(0, OP_ADD, 'hA1, 6, 1, 0,  0, 0, 0,    1, 'h14, 0, 0, 1));
    checkOutput("sq0_redir");
    checkVal("sq0_redir.redir_v0", 32'(bus0.redirect_valid),  32'd1);
    checkVal("sq0_redir.redir_t0", 32'(bus0.redirect_target), 32'h14);
    checkVal("sq0_redir.squash0",  32'(bus0.squash),          32'd0);
    applyStimulus(mk(0, OP_NOP, 0,    0, 0, 0,  0, 6, 'hA1, 0, 0,    1, 0, 1));
    checkOutput("sq0_next");
    checkVal("sq0_next.squash0",   32'(bus0.squash),   32'd0);
    checkVal("sq0_next.rf_we0",    32'(bus0.rf_we),    32'd1);
    checkVal("sq0_next.rf_waddr0", 32'(bus0.rf_waddr), 32'd6);
    checkVal("sq0_next.redir_v0",  32'(bus0.redirect_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
